// File: rtl/reg_bank_pc_pkg.sv
// rtl/reg_bank_pc_pkg.sv - shared constants and helpers for the register bank / PC
package reg_bank_pc_pkg;

  typedef logic [15:0] word_t;
  typedef logic [3:0]  reg_addr_t;

  // Architectural register indices
  localparam reg_addr_t REG_PC = 4'd0;
  localparam reg_addr_t REG_SP = 4'd1;
  localparam reg_addr_t REG_SR = 4'd2;
  localparam reg_addr_t REG_CG = 4'd3;

  // Status register flag positions
  localparam int SR_C = 0;
  localparam int SR_Z = 1;
  localparam int SR_N = 2;
  localparam int SR_V = 8;

  localparam word_t PC_STEP = 16'd2;

  // Signed word offset to byte displacement: sign-extend and scale by two
  function automatic word_t branch_disp(input logic [9:0] off);
    return {{5{off[9]}}, off, 1'b0};
  endfunction

endpackage

// File: rtl/reg_bank_pc_pc_next_calc.sv
// rtl/reg_bank_pc_pc_next_calc.sv - next-PC priority mux with branch adder
module pc_next_calc (
  input  logic [15:0] pc_q_i,
  input  logic        branch_en_i,
  input  logic [9:0]  pc_offset_i,
  input  logic        wr_pc_i,
  input  logic [15:0] wr_data_i,
  input  logic        pc_inc_i,
  input  logic        en_pc_2_i,
  output logic [15:0] pc_d_o
);
  import reg_bank_pc_pkg::*;

  // Branch beats an explicit PC write, which beats the sequential step; PC stays word aligned
  always_comb begin
    pc_d_o = pc_q_i;
    if (branch_en_i) begin
      pc_d_o = pc_q_i + branch_disp(pc_offset_i);
    end else if (wr_pc_i) begin
      pc_d_o = wr_data_i;
    end else if (pc_inc_i && en_pc_2_i) begin
      pc_d_o = pc_q_i + PC_STEP;
    end
    pc_d_o[0] = 1'b0;
  end

endmodule

// File: rtl/reg_bank_pc.sv
// rtl/reg_bank_pc.sv - register file with PC, SP, SR and constant generator
module reg_bank_pc #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] SP_INIT      = 16'h0400,
  parameter bit          BYPASS       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  src_reg,
  input  logic [3:0]  dst_reg,
  input  logic [3:0]  wr_reg,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        pc_inc,
  input  logic        en_pc_2,
  input  logic        branch_en,
  input  logic [9:0]  pc_offset,
  input  logic        flags_we,
  input  logic [3:0]  flags_in,
  output logic [15:0] src_data,
  output logic [15:0] dst_data,
  output logic [15:0] pc_out,
  output logic [15:0] sp_out,
  output logic [15:0] sr_out
);
  import reg_bank_pc_pkg::*;

  localparam logic [15:0] PC_RST = {RESET_VECTOR[15:1], 1'b0};
  localparam logic [15:0] SP_RST = {SP_INIT[15:1], 1'b0};

  logic [15:0] regs_q [16];
  logic [15:0] regs_d [16];
  logic [15:0] pc_d;
  logic [15:0] wr_store;
  logic        wr_pc;
  logic        wr_gp;

  assign wr_pc = wr_en && (wr_reg == REG_PC);
  assign wr_gp = wr_en && (wr_reg != REG_PC) && (wr_reg != REG_CG);

  // Value that a write actually commits: PC and SP are kept word aligned
  always_comb begin
    wr_store = wr_data;
    if (wr_reg == REG_PC || wr_reg == REG_SP) begin
      wr_store[0] = 1'b0;
    end
  end

  pc_next_calc u_pc_next (
    .pc_q_i      (regs_q[REG_PC]),
    .branch_en_i (branch_en),
    .pc_offset_i (pc_offset),
    .wr_pc_i     (wr_pc),
    .wr_data_i   (wr_data),
    .pc_inc_i    (pc_inc),
    .en_pc_2_i   (en_pc_2),
    .pc_d_o      (pc_d)
  );

  // Next state: PC from the priority mux, flags merged into SR, then explicit write overrides
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      regs_d[i] = regs_q[i];
    end
    regs_d[REG_PC] = pc_d;
    if (flags_we) begin
      regs_d[REG_SR][SR_C] = flags_in[0];
      regs_d[REG_SR][SR_Z] = flags_in[1];
      regs_d[REG_SR][SR_N] = flags_in[2];
      regs_d[REG_SR][SR_V] = flags_in[3];
    end
    if (wr_gp) begin
      regs_d[wr_reg] = wr_store;
    end
    regs_d[REG_CG] = 16'h0000;
  end

  // Register storage; R3 is pinned to zero and optimises away
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= 16'h0000;
      end
      regs_q[REG_PC] <= PC_RST;
      regs_q[REG_SP] <= SP_RST;
    end else begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Source read port with same-cycle write forwarding; suppressed during reset
  always_comb begin
    src_data = regs_q[src_reg];
    if (BYPASS && !rst && wr_en && (wr_reg == src_reg)) begin
      src_data = wr_store;
    end
    if (src_reg == REG_CG) begin
      src_data = 16'h0000;
    end
  end

  // Destination read port, same forwarding rules as the source port
  always_comb begin
    dst_data = regs_q[dst_reg];
    if (BYPASS && !rst && wr_en && (wr_reg == dst_reg)) begin
      dst_data = wr_store;
    end
    if (dst_reg == REG_CG) begin
      dst_data = 16'h0000;
    end
  end

  assign pc_out = regs_q[REG_PC];
  assign sp_out = regs_q[REG_SP];
  assign sr_out = regs_q[REG_SR];

endmodule

// File: tb/tb_reg_bank_pc.sv
// tb/tb_reg_bank_pc.sv - scoreboard bench for reg_bank_pc against a behavioural model
module tb_reg_bank_pc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  src_reg = '0;
  logic [3:0]  dst_reg = '0;
  logic [3:0]  wr_reg = '0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        pc_inc = 1'b0;
  logic        en_pc_2 = 1'b0;
  logic        branch_en = 1'b0;
  logic [9:0]  pc_offset = '0;
  logic        flags_we = 1'b0;
  logic [3:0]  flags_in = '0;
  logic [15:0] src_data, dst_data, pc_out, sp_out, sr_out;

  always #5 clk = ~clk;

  reg_bank_pc dut (
    .clk       (clk),
    .rst       (rst),
    .src_reg   (src_reg),
    .dst_reg   (dst_reg),
    .wr_reg    (wr_reg),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .pc_inc    (pc_inc),
    .en_pc_2   (en_pc_2),
    .branch_en (branch_en),
    .pc_offset (pc_offset),
    .flags_we  (flags_we),
    .flags_in  (flags_in),
    .src_data  (src_data),
    .dst_data  (dst_data),
    .pc_out    (pc_out),
    .sp_out    (sp_out),
    .sr_out    (sr_out)
  );

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] pc;
    logic [15:0] sp;
    logic [15:0] sr;
  } exp_t;

  exp_t exp_q[$];
  int   model_r[16];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_r[i] = 0;
    model_r[0] = 'h0000 & 'hFFFE;
    model_r[1] = 'h0400 & 'hFFFE;
  endtask

  function automatic int model_read(int a, bit r, bit we, int wa, int wd);
    if (a == 3) return 0;
    if (!r && we && wa == a) return (a <= 1) ? (wd & 'hFFFE) : wd;
    return model_r[a];
  endfunction

  task automatic cycle(input bit r, input int sa, input int da, input int wa, input bit we,
                       input int wd, input bit pinc, input bit e2, input bit br, input int off,
                       input bit fwe, input int fl);
    exp_t e;
    int   npc;
    int   soff;
    @(negedge clk);
    rst = r; src_reg = sa[3:0]; dst_reg = da[3:0]; wr_reg = wa[3:0]; wr_en = we;
    wr_data = wd[15:0]; pc_inc = pinc; en_pc_2 = e2; branch_en = br;
    pc_offset = off[9:0]; flags_we = fwe; flags_in = fl[3:0];
    if (r) model_reset();
    e.src = 16'(model_read(sa, r, we, wa, wd));
    e.dst = 16'(model_read(da, r, we, wa, wd));
    e.pc  = 16'(model_r[0]);
    e.sp  = 16'(model_r[1]);
    e.sr  = 16'(model_r[2]);
    exp_q.push_back(e);
    if (!r) begin
      npc = model_r[0];
      if (br) begin
        soff = (off >= 512) ? off - 1024 : off;
        npc = (model_r[0] + 2 * soff) & 'hFFFF;
      end else if (we && wa == 0) begin
        npc = wd & 'hFFFE;
      end else if (pinc && e2) begin
        npc = (model_r[0] + 2) & 'hFFFF;
      end
      if (fwe) begin
        model_r[2] = (model_r[2] & ~'h0107) | (fl[0] ? 'h1 : 0) | (fl[1] ? 'h2 : 0)
                   | (fl[2] ? 'h4 : 0) | (fl[3] ? 'h100 : 0);
      end
      if (we && wa != 0 && wa != 3) model_r[wa] = (wa == 1) ? (wd & 'hFFFE) : wd;
      model_r[0] = npc;
    end
  endtask

  task automatic idle(input int sa, input int da);
    cycle(0, sa, da, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int wa, input int wd, input int sa);
    cycle(0, sa, wa, wa, 1, wd, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: pops the expected response for each presented cycle and compares
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("src_data", src_data, e.src);
        chk("dst_data", dst_data, e.dst);
        chk("pc_out", pc_out, e.pc);
        chk("sp_out", sp_out, e.sp);
        chk("sr_out", sr_out, e.sr);
      end
    end
  end

  initial begin
    model_reset();
    cycle(1, 4, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 7, 9, 5, 1, 'h5555, 1, 1, 0, 0, 1, 'hF);

    // Write with same-cycle forwarding, then R3 discard
    cycle(0, 5, 6, 5, 1, 'hBEEF, 0, 0, 0, 0, 0, 0);
    idle(5, 3);
    cycle(0, 3, 3, 3, 1, 'h1234, 0, 0, 0, 0, 0, 0);
    idle(3, 5);

    // PC wrap and hold cases
    wr(0, 'hFFFE, 0);
    cycle(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(0, 0);

    // Branches, including priority over the sequential step
    wr(0, 'h0100, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h3FF, 0, 0);
    wr(0, 'h0100, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h1FF, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 1, 1, 'h200, 0, 0);
    idle(0, 0);

    // Flags into SR and explicit write winning over flags
    wr(2, 'h0000, 2);
    cycle(0, 2, 2, 0, 0, 0, 0, 0, 0, 0, 1, 'hF);
    cycle(0, 2, 2, 2, 1, 'h00F0, 0, 0, 0, 0, 1, 'hF);
    idle(2, 2);

    // PC/SP alignment on write; R0 write beats step; GP write alongside PC step
    cycle(0, 0, 1, 0, 1, 'h2001, 1, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 1, 'h0333, 0, 0, 0, 0, 0, 0);
    cycle(0, 9, 1, 9, 1, 'hA5A5, 1, 1, 0, 0, 0, 0);
    idle(9, 1);

    // Reset mid-run with all strobes active, then sweep R4..R15
    cycle(1, 4, 15, 6, 1, 'h7777, 1, 1, 1, 'h155, 1, 'hF);
    for (int i = 4; i < 16; i += 2) idle(i, i + 1);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 39) == 0), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 'hFFFF),
            $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 7) == 0),
            $urandom_range(0, 1023), $urandom_range(0, 1), $urandom_range(0, 15));
    end
    idle(0, 1);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #5;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d responses left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
